load_store_unit: RTL and testbench

- Memory-stage front end that sits directly upstream of the word-addressed, synchronous-read data memory in the pipelined datapath.
- Accepts byte-addressed load/store requests from the EX/MEM pipeline register and converts byte/halfword/word accesses into word accesses on the memory port.
- Sub-word stores use read-modify-write. Loads are extracted and sign- or zero-extended.
- Stalls the pipeline while a multi-cycle access is in flight.

---
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store front end for a word-addressed, synchronous-read data memory.
// It handles byte, halfword and word accesses; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int unsigned DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        access_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, READ, EXTRACT, MERGE, WRITE} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_is_store;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_access_err;

    logic        w_bad;
    logic        w_err;
    logic        w_accept;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign w_bad = (req_read & req_write) | (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                 | (req_addr[31:2] >= 30'(DEPTH));
    // Neither read nor write set is a bubble, not an error.
    assign w_err    = req_valid & (req_read | req_write) & w_bad;
    assign w_accept = req_valid & (req_read ^ req_write) & ~w_bad;

    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_ext = mem_rdata;
        case (r_size)
            2'b00:   w_load_ext = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // Store data sits right-aligned in r_mem_wdata until it is merged into the read word.
    always_comb begin
        w_merged = mem_rdata;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_mem_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_mem_wdata[7:0];
                2'd2:    w_merged[23:16] = r_mem_wdata[7:0];
                default: w_merged[31:24] = r_mem_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_mem_wdata[15:0];
        end else begin
            w_merged[15:0] = r_mem_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_is_store   <= 1'b0;
            r_mem_wdata  <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_access_err <= (r_state == IDLE) & w_err;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= req_addr;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_is_store  <= req_write;
                        r_mem_wdata <= req_wdata;
                        r_state     <= (req_write && req_size == 2'b10) ? WRITE : READ;
                    end
                end
                READ:    r_state <= r_is_store ? MERGE : EXTRACT;
                EXTRACT: begin
                    r_load_data  <= w_load_ext;
                    r_load_valid <= 1'b1;
                    r_state      <= IDLE;
                end
                MERGE: begin
                    r_mem_wdata <= w_merged;
                    r_state     <= WRITE;
                end
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall       = (r_state != IDLE);
    assign mem_read    = (r_state == READ);
    assign mem_write   = (r_state == WRITE);
    assign mem_address = {2'b00, r_addr[31:2]};
    assign mem_wdata   = r_mem_wdata;
    assign load_valid  = r_load_valid;
    assign load_data   = r_load_data;
    assign access_err  = r_access_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous-read memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_read, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid, access_err, mem_read, mem_write;
    logic [31:0] load_data, mem_address, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:9];
    int unsigned n_wr = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_valid(load_valid), .load_data(load_data),
        .access_err(access_err), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_read && mem_address < 32'd10) mem_rdata <= mem[mem_address[3:0]];
        if (mem_write && mem_address < 32'd10) mem[mem_address[3:0]] <= mem_wdata;
        if (mem_write) n_wr <= n_wr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] exp);
        drive(1'b1, 1'b0, size, uns, addr, '0);
        step(); idle_req();
        check({tag, "_rd1"}, mem_read, 1);
        check({tag, "_stall1"}, stall, 1);
        check({tag, "_addr"}, mem_address, addr >> 2);
        step();
        check({tag, "_rd2"}, mem_read, 0);
        check({tag, "_stall2"}, stall, 1);
        check({tag, "_lv2"}, load_valid, 0);
        step();
        check({tag, "_lv3"}, load_valid, 1);
        check({tag, "_data"}, load_data, exp);
        check({tag, "_stall3"}, stall, 0);
    endtask

    task automatic do_store_word(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int unsigned c;
        drive(1'b0, 1'b1, 2'b10, 1'b0, addr, data);
        step(); idle_req();
        c = n_wr;
        check({tag, "_we"}, mem_write, 1);
        check({tag, "_rd"}, mem_read, 0);
        check({tag, "_wdata"}, mem_wdata, data);
        check({tag, "_stall"}, stall, 1);
        step();
        check({tag, "_idle"}, stall, 0);
        check({tag, "_nwr"}, n_wr, c + 1);
    endtask

    task automatic do_store_sub(input string tag, input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] data, input logic [31:0] exp);
        int unsigned c;
        c = n_wr;
        drive(1'b0, 1'b1, size, 1'b0, addr, data);
        step(); idle_req();
        check({tag, "_rd1"}, mem_read, 1);
        check({tag, "_we1"}, mem_write, 0);
        check({tag, "_stall1"}, stall, 1);
        step();
        check({tag, "_we2"}, mem_write, 0);
        check({tag, "_stall2"}, stall, 1);
        step();
        check({tag, "_we3"}, mem_write, 1);
        check({tag, "_wdata"}, mem_wdata, exp);
        check({tag, "_addr"}, mem_address, addr >> 2);
        check({tag, "_stall3"}, stall, 1);
        step();
        check({tag, "_idle"}, stall, 0);
        check({tag, "_nwr"}, n_wr, c + 1);
    endtask

    task automatic do_err(input string tag, input logic rd, input logic wr,
                          input logic [1:0] size, input logic [31:0] addr);
        drive(rd, wr, size, 1'b0, addr, 32'hDEAD_BEEF);
        step(); idle_req();
        check({tag, "_err"}, access_err, 1);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_rd"}, mem_read, 0);
        check({tag, "_we"}, mem_write, 0);
        step();
        check({tag, "_err_off"}, access_err, 0);
        check({tag, "_stall2"}, stall, 0);
    endtask

    initial begin
        int unsigned c;
        rst = 1'b0;
        idle_req();
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        step(); step();
        check("rst_stall", stall, 0);
        check("rst_lv", load_valid, 0);
        check("rst_err", access_err, 0);
        check("rst_rd", mem_read, 0);
        check("rst_we", mem_write, 0);
        check("rst_ldata", load_data, 0);
        check("rst_maddr", mem_address, 0);
        check("rst_mwdata", mem_wdata, 0);
        rst = 1'b1;
        step();

        do_store_word("sw_w2", 32'h8, 32'h1122_3344);
        do_store_word("sw_w3", 32'hC, 32'h80FF_7F01);
        do_load("lw_8", 32'h8, 2'b10, 1'b0, 32'h1122_3344);
        do_load("lb_D", 32'hD, 2'b00, 1'b0, 32'h0000_007F);
        do_load("lb_E", 32'hE, 2'b00, 1'b0, 32'hFFFF_FFFF);
        do_load("lbu_E", 32'hE, 2'b00, 1'b1, 32'h0000_00FF);
        do_load("lh_E", 32'hE, 2'b01, 1'b0, 32'hFFFF_80FF);
        do_load("lhu_C", 32'hC, 2'b01, 1'b1, 32'h0000_7F01);

        do_store_sub("sb_9", 32'h9, 2'b00, 32'h1234_56AA, 32'h1122_AA44);
        do_load("lw_after_sb", 32'h8, 2'b10, 1'b0, 32'h1122_AA44);
        do_store_word("sw_restore", 32'h8, 32'h1122_3344);
        do_store_sub("sh_A", 32'hA, 2'b01, 32'h0000_BEEF, 32'hBEEF_3344);
        do_load("lw_b2b", 32'h8, 2'b10, 1'b0, 32'hBEEF_3344);

        do_err("err_lw6", 1'b1, 1'b0, 2'b10, 32'h6);
        do_err("err_sh3", 1'b0, 1'b1, 2'b01, 32'h3);
        do_err("err_lw28", 1'b1, 1'b0, 2'b10, 32'h28);
        do_err("err_size3", 1'b1, 1'b0, 2'b11, 32'h8);
        do_err("err_rdwr", 1'b1, 1'b1, 2'b10, 32'h8);

        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h8, '0);
        step(); idle_req();
        check("nop_err", access_err, 0);
        check("nop_stall", stall, 0);
        check("nop_rd", mem_read, 0);

        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h0000_0055);
        step(); idle_req();
        step();
        check("rstmid_merge_stall", stall, 1);
        c = n_wr;
        rst = 1'b0;
        #1;
        check("rstmid_stall", stall, 0);
        check("rstmid_we", mem_write, 0);
        check("rstmid_ldata", load_data, 0);
        check("rstmid_maddr", mem_address, 0);
        step(); step();
        check("rstmid_nwr", n_wr, c);
        rst = 1'b1;
        step();
        do_load("lw_after_rst", 32'h8, 2'b10, 1'b0, 32'hBEEF_3344);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
